// File: rtl/llfifo_pkg.sv
// Shared types for the linked-list FIFO and its command front end.
// Queue IDs, payload word and per-queue non-empty flags.
package llfifo_pkg;

  localparam int ID_N   = 4;
  localparam int PTR_N  = 16;
  localparam int WORD_W = 8;

  typedef logic [$clog2(ID_N)-1:0] id_t;
  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [ID_N-1:0]         empty_t;

endpackage

// File: rtl/llfifo_cmd_arb.sv
// Push/pop command arbiter in front of the linked-list FIFO: one command per
// cycle, round-robin on contention, in-order pop responses one cycle later.
module llfifo_cmd_arb
  import llfifo_pkg::*;
#(
  parameter bit POP_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,

  input  logic   push_vld,
  output logic   push_rdy,
  input  id_t    push_id,
  input  word_t  push_data,

  input  logic   pop_vld,
  output logic   pop_rdy,
  input  id_t    pop_id,

  output logic   rsp_vld,
  output logic   rsp_err,
  output id_t    rsp_id,
  output word_t  rsp_data,

  output logic   cmd_pass,
  output logic   cmd_push,
  output id_t    cmd_id,
  output word_t  cmd_push_data,

  input  word_t  cmd_pop_data,
  input  logic   full_r,
  input  empty_t nempty_r,
  input  logic   busy_r
);

  logic  hold_vld;
  id_t   hold_id;
  word_t hold_data;
  logic  rr_pop;

  logic  rsp_vld_q;
  logic  rsp_err_q;
  id_t   rsp_id_q;

  logic  push_elig;
  logic  pop_elig;
  logic  pop_err;
  logic  contend;
  logic  grant_push;
  logic  grant_pop;
  logic  push_hs;

  always_comb begin
    push_elig  = hold_vld & ~full_r & ~busy_r;
    pop_elig   = pop_vld & ~busy_r & nempty_r[pop_id];
    pop_err    = pop_vld & ~busy_r & ~nempty_r[pop_id];
    contend    = push_elig & pop_elig;
    grant_pop  = pop_elig & (~push_elig | rr_pop);
    grant_push = push_elig & (~pop_elig | ~rr_pop);
  end

  // Handshake outputs are forced low while reset is held.
  always_comb begin
    push_rdy      = rst_n & (~hold_vld | grant_push);
    pop_rdy       = rst_n & (grant_pop | pop_err);
    cmd_pass      = rst_n & (grant_push | grant_pop);
    cmd_push      = grant_push;
    cmd_id        = grant_push ? hold_id : pop_id;
    cmd_push_data = hold_data;
    push_hs       = push_vld & push_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_id   <= '0;
      hold_data <= '0;
    end else if (push_hs) begin
      hold_vld  <= 1'b1;
      hold_id   <= push_id;
      hold_data <= push_data;
    end else if (grant_push) begin
      hold_vld  <= 1'b0;
    end
  end

  // The flag only moves when both sides competed for the command slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_pop <= POP_FIRST;
    end else if (contend) begin
      rr_pop <= ~rr_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      rsp_vld_q <= pop_rdy;
      rsp_err_q <= pop_err;
      if (pop_rdy) begin
        rsp_id_q <= pop_id;
      end
    end
  end

  // Read data arrives from the SRAM one cycle after the pop command.
  always_comb begin
    rsp_vld  = rst_n & rsp_vld_q;
    rsp_err  = rsp_err_q;
    rsp_id   = rsp_id_q;
    rsp_data = (rsp_vld_q & ~rsp_err_q) ? cmd_pop_data : '0;
  end

endmodule
